// File: rtl/neuron_pkg.sv
// Shared types and width helpers for the sequential neuron datapath.
package neuron_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StAct, StDone} state_e;

  localparam int unsigned DefN  = 2;
  localparam int unsigned DefQM = 6;
  localparam int unsigned DefQN = 10;
  localparam int unsigned DefWM = 6;
  localparam int unsigned DefWN = 10;

  function automatic int unsigned prod_width(input int unsigned qm, input int unsigned qn,
                                             input int unsigned wm, input int unsigned wn);
    return qm + qn + wm + wn;
  endfunction

  // One guard bit per doubling of terms plus one for the bias makes overflow impossible.
  function automatic int unsigned acc_width(input int unsigned qm, input int unsigned qn,
                                            input int unsigned wm, input int unsigned wn,
                                            input int unsigned n);
    return prod_width(qm, qn, wm, wn) + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with a registered product stage; clr_i loads the aligned bias.
module mac_unit
  import neuron_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned QM = DefQM,
  parameter int unsigned QN = DefQN,
  parameter int unsigned WM = DefWM,
  parameter int unsigned WN = DefWN
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clr_i,
  input  logic                                  en_i,
  input  logic [QM+QN-1:0]                      bias_i,
  input  logic [QM+QN-1:0]                      a_i,
  input  logic [WM+WN-1:0]                      b_i,
  output logic [acc_width(QM, QN, WM, WN, N)-1:0] acc_o
);

  localparam int unsigned AW   = QM + QN;
  localparam int unsigned PW   = prod_width(QM, QN, WM, WN);
  localparam int unsigned AccW = acc_width(QM, QN, WM, WN, N);

  logic signed [PW-1:0] prod_d, prod_q;
  logic                 prod_vld_d, prod_vld_q;
  logic [AccW-1:0]      acc_d, acc_q;

  always_comb begin
    prod_d     = prod_q;
    prod_vld_d = en_i;
    acc_d      = acc_q;
    if (en_i) begin
      prod_d = $signed(a_i) * $signed(b_i);
    end
    if (clr_i) begin
      // Bias is QM.QN; shifting by WN aligns it with the QM+WM.QN+WN products.
      acc_d      = {{(AccW-AW-WN){bias_i[AW-1]}}, bias_i, {WN{1'b0}}};
      prod_vld_d = 1'b0;
    end else if (prod_vld_q) begin
      acc_d = acc_q + {{(AccW-PW){prod_q[PW-1]}}, prod_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Sequential single-multiplier neuron: bias + sum(in*w), then ReLU.
// Define SAT_EN to clamp large positive results instead of wrapping.
module neuron_seq_ctrl
  import neuron_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned QM = DefQM,
  parameter int unsigned QN = DefQN,
  parameter int unsigned WM = DefWM,
  parameter int unsigned WN = DefWN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N-1:0][QM+QN-1:0]    in_data,
  input  logic [N-1:0][WM+WN-1:0]    weights,
  input  logic [QM+QN-1:0]           bias,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [QM+QN-1:0]           out_data
);

  localparam int unsigned AW   = QM + QN;
  localparam int unsigned BW   = WM + WN;
  localparam int unsigned AccW = acc_width(QM, QN, WM, WN, N);
  localparam int unsigned SW   = AccW - WN;
  localparam int unsigned IdxW = $clog2(N + 1);
  localparam logic [IdxW-1:0] IdxDrain = IdxW'(N);
`ifdef SAT_EN
  localparam logic [AW-1:0] MaxPos = {1'b0, {(AW-1){1'b1}}};
`endif

  state_e                 state_d, state_q;
  logic [IdxW-1:0]        idx_d, idx_q;
  logic [N-1:0][AW-1:0]   in_d, in_q;
  logic [N-1:0][BW-1:0]   w_d, w_q;
  logic [AW-1:0]          out_data_d, out_data_q;
  logic                   out_valid_d, out_valid_q;
  logic                   busy_d, busy_q;

  logic                   mac_clr, mac_en;
  logic [AW-1:0]          mac_a;
  logic [BW-1:0]          mac_b;
  logic [AccW-1:0]        acc;
  logic [SW-1:0]          scaled;
  logic [AW-1:0]          act_res;
  logic                   unused_acc_frac;

  mac_unit #(
    .N  (N),
    .QM (QM),
    .QN (QN),
    .WM (WM),
    .WN (WN)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .bias_i (bias),
    .a_i    (mac_a),
    .b_i    (mac_b),
    .acc_o  (acc)
  );

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        mac_a = in_q[i];
        mac_b = w_q[i];
      end
    end
  end

  // Dropping the WN low bits is the arithmetic shift (floor toward -inf).
  assign scaled          = acc[AccW-1:WN];
  assign unused_acc_frac = ^acc[WN-1:0];

  always_comb begin
    act_res = '0;
    if (!scaled[SW-1] && (scaled != '0)) begin
`ifdef SAT_EN
      if (|scaled[SW-2:AW-1]) begin
        act_res = MaxPos;
      end else begin
        act_res = scaled[AW-1:0];
      end
`else
      act_res = scaled[AW-1:0];
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    in_d       = in_q;
    w_d        = w_q;
    out_data_d = out_data_q;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          in_d    = in_data;
          w_d     = weights;
          idx_d   = '0;
          mac_clr = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        // Extra pass at idx==N lets the last registered product reach the accumulator.
        if (idx_q == IdxDrain) begin
          idx_d   = '0;
          state_d = StAct;
        end else begin
          mac_en = 1'b1;
          idx_d  = idx_q + 1'b1;
        end
      end
      StAct: begin
        out_data_d = act_res;
        state_d    = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d      = (state_d != StIdle);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      in_q        <= '0;
      w_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_q        <= in_d;
      w_q         <= w_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Scoreboarded bench for neuron_seq_ctrl (N=2, Q6.10 data, Q6.10 weights).
module tb_neuron_seq_ctrl;

  localparam int unsigned N  = 2;
  localparam int unsigned QM = 6;
  localparam int unsigned QN = 10;
  localparam int unsigned WM = 6;
  localparam int unsigned WN = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             out_ready = 1'b0;
  logic [1:0][15:0] in_data = '0;
  logic [1:0][15:0] weights = '0;
  logic [15:0]      bias = '0;
  logic             busy;
  logic             out_valid;
  logic [15:0]      out_data;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  neuron_seq_ctrl #(
    .N  (N),
    .QM (QM),
    .QN (QN),
    .WM (WM),
    .WN (WN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .weights   (weights),
    .bias      (bias),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Real-number view: bias + sum(x*w) in Q.20, floor to Q.10, ReLU, then clamp or wrap.
  function automatic logic [15:0] model(input logic [15:0] i0, input logic [15:0] i1,
                                        input logic [15:0] w0, input logic [15:0] w1,
                                        input logic [15:0] b);
    longint sum;
    longint s;
    sum = longint'($signed(b)) * 1024
        + longint'($signed(i0)) * longint'($signed(w0))
        + longint'($signed(i1)) * longint'($signed(w1));
    s = sum >>> 10;
    if (s <= 0) return 16'd0;
`ifdef SAT_EN
    if (s > 32767) return 16'h7FFF;
`endif
    return s[15:0];
  endfunction

  task automatic scramble();
    in_data[0] = 16'($urandom);
    in_data[1] = 16'($urandom);
    weights[0] = 16'($urandom);
    weights[1] = 16'($urandom);
    bias       = 16'($urandom);
  endtask

  // Monitor: every handshake pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got out_data=%0d with no pending result", out_data);
      end else begin
        chk("sb_out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_before_start", busy, 0);
  endtask

  task automatic do_eval(input logic [15:0] i0, input logic [15:0] i1,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] b, input logic [15:0] expv,
                         input int hold, input logic start_at_hs);
    int lat;
    wait_idle();
    in_data[0] = i0;
    in_data[1] = i1;
    weights[0] = w0;
    weights[1] = w1;
    bias       = b;
    start      = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, N + 2);
    for (int j = 0; j < hold; j++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_data", out_data, expv);
      start = 1'b1;
      scramble();
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    out_ready = 1'b1;
    start     = start_at_hs;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    start     = 1'b0;
    chk("idle_after_hs", {busy, out_valid}, 0);
    chk("retain_data", out_data, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] r0, r1, q0, q1, rb;
    logic [15:0] big_exp;
`ifdef SAT_EN
    big_exp = 16'h7FFF;
`else
    big_exp = 16'd2048;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_eval(16'd1024, 16'd0, 16'd2048, 16'd0, 16'd0, 16'd2048, 0, 1'b0);
    do_eval(16'd1024, 16'd0, 16'hFC00, 16'd0, 16'd0, 16'd0, 1, 1'b1);
    do_eval(16'd0, 16'd0, 16'd0, 16'd0, 16'd512, 16'd512, 5, 1'b1);
    do_eval(16'd31744, 16'd31744, 16'd31744, 16'd31744, 16'd0, big_exp, 2, 1'b0);

    // Abort an evaluation mid-MAC; out_data currently holds a nonzero result.
    wait_idle();
    in_data[0] = 16'd1024;
    weights[0] = 16'd1024;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mac_busy", busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_eval(16'd1024, 16'd0, 16'd2048, 16'd0, 16'd0, 16'd2048, 0, 1'b0);

    repeat (24) begin
      if ($urandom_range(0, 1) == 1) begin
        r0 = 16'($urandom_range(0, 8191)) - 16'd4096;
        r1 = 16'($urandom_range(0, 8191)) - 16'd4096;
        q0 = 16'($urandom_range(0, 8191)) - 16'd4096;
        q1 = 16'($urandom_range(0, 8191)) - 16'd4096;
        rb = 16'($urandom_range(0, 8191)) - 16'd4096;
      end else begin
        r0 = 16'($urandom);
        r1 = 16'($urandom);
        q0 = 16'($urandom);
        q1 = 16'($urandom);
        rb = 16'($urandom);
      end
      do_eval(r0, r1, q0, q1, rb, model(r0, r1, q0, q1, rb), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
